seq_alu: RTL and testbench

Parametrised, multi-cycle successor to the processor's single-cycle ALU. Executes the same 12-operation control encoding on WIDTH-bit operands, with an iterative radix-2 Booth multiplier and an iterative non-restoring divider. Results are delivered through a start/busy/done handshake. It sits between the register-file read ports and the Z register, and the control unit stalls on `busy`.

---
 rtl/seq_alu_pkg.sv | 36 +++
 rtl/seq_alu_if.sv | 24 ++
 rtl/seq_alu_muldiv.sv | 105 ++++++++++
 rtl/seq_alu.sv | 145 ++++++++++++++
 tb/tb_seq_alu.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_alu_pkg.sv
// seq_alu shared definitions: op codes, FSM states, latency constants.
// Optional divider is enabled with `define SEQ_ALU_DIV_EN.
package seq_alu_pkg;

  localparam logic [3:0] OP_DIV = 4'd0;
  localparam logic [3:0] OP_MUL = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ROL = 4'd7;
  localparam logic [3:0] OP_OR  = 4'd8;
  localparam logic [3:0] OP_NEG = 4'd9;
  localparam logic [3:0] OP_AND = 4'd10;
  localparam logic [3:0] OP_NOT = 4'd11;

  typedef enum logic [2:0] {
    IDLE,
    MUL,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam int ALU_LAT_SINGLE = 1;

  function automatic int alu_lat_mul(int w);
    return w + 1;
  endfunction

  function automatic int alu_lat_div(int w);
    return w + 2;
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu request/result bundle with start/busy/done handshake.
// master = issuing control unit, slave = seq_alu.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic [3:0]         control;
  logic [WIDTH-1:0]   reg1;
  logic [WIDTH-1:0]   reg2;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] z_Output;
  logic               div_by_zero;

  modport master (
    output start, control, reg1, reg2,
    input  busy, done, z_Output, div_by_zero
  );

  modport slave (
    input  start, control, reg1, reg2,
    output busy, done, z_Output, div_by_zero
  );
endinterface

// File: rtl/seq_alu_muldiv.sv
// Shared iterative datapath: radix-2 Booth multiply and (with
// SEQ_ALU_DIV_EN) non-restoring unsigned divide on one accumulator.
module seq_alu_muldiv #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               run,
`ifdef SEQ_ALU_DIV_EN
  input  logic               mul,
  input  logic               fix,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] prod
);

  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] opd;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   hi_x;
  logic [WIDTH:0]   m_x;
  logic [WIDTH:0]   bsum;
  logic [2*WIDTH:0] booth_nx;

  assign last = run && (cnt == CW'(WIDTH - 1));
  assign prod = acc[2*WIDTH:1];

  // Sum kept one bit wider so subtracting the most negative
  // multiplicand cannot overflow before the arithmetic shift.
  always_comb begin
    hi_x = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    m_x  = {opd[WIDTH-1], opd};
    bsum = hi_x;
    if (acc[1:0] == 2'b01) bsum = hi_x + m_x;
    if (acc[1:0] == 2'b10) bsum = hi_x - m_x;
    booth_nx = {bsum, acc[WIDTH:1]};
  end

`ifdef SEQ_ALU_DIV_EN
  logic             is_mul;
  logic [WIDTH:0]   rr;
  logic [WIDTH+1:0] rsh;
  logic [WIDTH+1:0] rs;
  logic [2*WIDTH:0] div_nx;

  assign rr   = acc[2*WIDTH:WIDTH];
  assign quot = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];

  // Shifted remainder needs WIDTH+2 bits; result fits WIDTH+1.
  always_comb begin
    rsh = {rr, acc[WIDTH-1]};
    if (rr[WIDTH]) rs = rsh + {2'b00, opd};
    else           rs = rsh - {2'b00, opd};
    div_nx = {rs[WIDTH:0], acc[WIDTH-2:0], ~rs[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opd    <= '0;
      cnt    <= '0;
      is_mul <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      is_mul <= mul;
      if (mul) begin
        acc <= {{WIDTH{1'b0}}, b, 1'b0};
        opd <= a;
      end else begin
        acc <= {{(WIDTH+1){1'b0}}, a};
        opd <= b;
      end
    end else if (run) begin
      cnt <= cnt + CW'(1);
      acc <= is_mul ? booth_nx : div_nx;
    end else if (fix && rr[WIDTH]) begin
      acc[2*WIDTH:WIDTH] <= rr + {1'b0, opd};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      opd <= '0;
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
      acc <= {{WIDTH{1'b0}}, b, 1'b0};
      opd <= a;
    end else if (run) begin
      cnt <= cnt + CW'(1);
      acc <= booth_nx;
    end
  end
`endif

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU top: FSM, start/busy/done handshake, single-cycle ops.
// `define SEQ_ALU_DIV_EN compiles in the divider and div_by_zero.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input logic     Clk,
  input logic     Rst_n,
  seq_alu_if.slave io
);

  localparam logic [SHW:0] WW = (SHW + 1)'(WIDTH);

  state_t               state;
  logic [3:0]           op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   z;
  logic [2*WIDTH-1:0]   z_next;
  logic [WIDTH-1:0]     res;
  logic [SHW-1:0]       s;
  logic [SHW:0]         inv;
  logic                 accept;
  logic                 md_run;
  logic                 md_last;
  logic [2*WIDTH-1:0]   prod;

  assign accept = (state == IDLE) && !busy && io.start;
  assign md_run = (state == MUL) || (state == DIV);

  assign io.busy     = busy;
  assign io.done     = done;
  assign io.z_Output = z;

`ifdef SEQ_ALU_DIV_EN
  logic             dbz;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  assign io.div_by_zero = dbz;
`else
  assign io.div_by_zero = 1'b0;
`endif

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (Clk),
    .rst_n (Rst_n),
    .load  (accept),
    .run   (md_run),
`ifdef SEQ_ALU_DIV_EN
    .mul   (io.control == OP_MUL),
    .fix   (state == FIX),
    .quot  (quot),
    .rem   (rem),
`endif
    .a     (io.reg1),
    .b     (io.reg2),
    .last  (md_last),
    .prod  (prod)
  );

  assign s   = b[SHW-1:0];
  assign inv = WW - {1'b0, s};

  // inv = WIDTH when s = 0, so the wrap term shifts out entirely.
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_SLL:  res = a << s;
      OP_SRL:  res = a >> s;
      OP_ROR:  res = (a >> s) | (a << inv);
      OP_ROL:  res = (a << s) | (a >> inv);
      OP_OR:   res = a | b;
      OP_NEG:  res = '0 - b;
      OP_AND:  res = a & b;
      OP_NOT:  res = ~b;
      default: res = '0;
    endcase
  end

  always_comb begin
    z_next = {{WIDTH{1'b0}}, res};
    if (op == OP_MUL) z_next = prod;
`ifdef SEQ_ALU_DIV_EN
    if (op == OP_DIV)
      z_next = (b == '0) ? {a, {WIDTH{1'b1}}} : {rem, quot};
`endif
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      op    <= '0;
      a     <= '0;
      b     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      z     <= '0;
`ifdef SEQ_ALU_DIV_EN
      dbz   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (done) begin
            done <= 1'b0;
            busy <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            dbz  <= 1'b0;
`endif
          end else if (accept) begin
            op    <= io.control;
            a     <= io.reg1;
            b     <= io.reg2;
            busy  <= 1'b1;
            state <= DONE;
            if (io.control == OP_MUL) state <= MUL;
`ifdef SEQ_ALU_DIV_EN
            if (io.control == OP_DIV && io.reg2 != '0)
              state <= DIV;
`endif
          end
        end
        MUL:  if (md_last) state <= DONE;
        DIV:  if (md_last) state <= FIX;
        FIX:  state <= DONE;
        DONE: begin
          z     <= z_next;
          done  <= 1'b1;
          state <= IDLE;
`ifdef SEQ_ALU_DIV_EN
          dbz   <= (op == OP_DIV) && (b == '0);
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu (32-bit and 8-bit instances).
// Divide expectations follow whether SEQ_ALU_DIV_EN is defined.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(32)) b32 ();
  seq_alu_if #(.WIDTH(8))  b8 ();

  seq_alu #(.WIDTH(32)) dut (
    .Clk   (clk),
    .Rst_n (rst_n),
    .io    (b32.slave)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .Clk   (clk),
    .Rst_n (rst_n),
    .io    (b8.slave)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle32();
    int k = 0;
    @(negedge clk);
    while (b32.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  // Accept at edge N; lat = edges after N until done is seen.
  task automatic run32(input logic [3:0] ctl, input logic [31:0] r1,
                       input logic [31:0] r2, output int lat);
    wait_idle32();
    b32.start = 1'b1;
    b32.control = ctl;
    b32.reg1 = r1;
    b32.reg2 = r2;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    b32.control = OP_ADD;
    b32.reg1 = 32'hDEAD_BEEF;
    b32.reg2 = 32'h1234_5678;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (b32.done) break;
    end
  endtask

  task automatic op32(input string tag, input logic [3:0] ctl,
                      input logic [31:0] r1, input logic [31:0] r2,
                      input logic [63:0] exp_z, input int exp_lat);
    int lat;
    run32(ctl, r1, r2, lat);
    check({tag, "_z"}, b32.z_Output, exp_z);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic run8(input logic [3:0] ctl, input logic [7:0] r1,
                      input logic [7:0] r2, output int lat);
    int k = 0;
    @(negedge clk);
    while (b8.busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    b8.start = 1'b1;
    b8.control = ctl;
    b8.reg1 = r1;
    b8.reg2 = r2;
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    b8.reg1 = 8'h5A;
    b8.reg2 = 8'hA5;
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (b8.done) break;
    end
  endtask

  localparam int LM = alu_lat_mul(32);
`ifdef SEQ_ALU_DIV_EN
  localparam int LD = alu_lat_div(32);
`else
  localparam int LD = ALU_LAT_SINGLE;
`endif

  initial begin
    int lat;
    int seen;
    int cyc;
    logic [63:0] zprev;

    b32.start = 1'b0;
    b32.control = '0;
    b32.reg1 = '0;
    b32.reg2 = '0;
    b8.start = 1'b0;
    b8.control = '0;
    b8.reg1 = '0;
    b8.reg2 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_z", b32.z_Output, 64'h0);
    check("rst_done", 64'(b32.done), 64'h0);
    check("rst_busy", 64'(b32.busy), 64'h0);
    check("rst_dbz", 64'(b32.div_by_zero), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    op32("add", OP_ADD, 32'd5, 32'd7, 64'd12, ALU_LAT_SINGLE);
    check("done_busy", 64'(b32.busy), 64'h1);
    op32("sub", OP_SUB, 32'd3, 32'd5, 64'h0000_0000_FFFF_FFFE, 1);
    op32("sll", OP_SLL, 32'd1, 32'd31, 64'h8000_0000, 1);
    op32("srl31", OP_SRL, 32'h8000_0000, 32'd31, 64'h1, 1);
    op32("rol0", OP_ROL, 32'h8000_0001, 32'd0, 64'h8000_0001, 1);
    op32("rol33", OP_ROL, 32'h8000_0001, 32'd33, 64'h3, 1);
    op32("ror4", OP_ROR, 32'h8000_0001, 32'd4, 64'h1800_0000, 1);
    op32("ror0", OP_ROR, 32'h1234_5678, 32'd64, 64'h1234_5678, 1);
    op32("or", OP_OR, 32'h0000_F0F0, 32'h0000_0F00, 64'hFFF0, 1);
    op32("neg", OP_NEG, 32'd0, 32'd1, 64'hFFFF_FFFF, 1);
    op32("and", OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0,
         64'h0F00_0F00, 1);
    op32("not", OP_NOT, 32'd0, 32'd0, 64'hFFFF_FFFF, 1);
    op32("illegal", 4'd12, 32'd9, 32'd9, 64'h0, 1);
    op32("addwrap", OP_ADD, 32'hFFFF_FFFF, 32'd1, 64'h0, 1);

    op32("mul_neg", OP_MUL, 32'hFFFF_FFFD, 32'd7,
         64'hFFFF_FFFF_FFFF_FFEB, LM);
    op32("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000,
         64'h4000_0000_0000_0000, LM);
    op32("mul_mix", OP_MUL, 32'd1000, 32'hFFFF_FFFE,
         64'hFFFF_FFFF_FFFF_F830, LM);

`ifdef SEQ_ALU_DIV_EN
    op32("div", OP_DIV, 32'd100, 32'd7, 64'h0000_0002_0000_000E, LD);
    check("div_dbz", 64'(b32.div_by_zero), 64'h0);
    op32("divbig", OP_DIV, 32'hFFFF_FFFF, 32'h10,
         64'h0000_000F_0FFF_FFFF, LD);
    op32("div0", OP_DIV, 32'd55, 32'd0, 64'h0000_0037_FFFF_FFFF, 1);
    check("div0_dbz", 64'(b32.div_by_zero), 64'h1);
`else
    op32("div", OP_DIV, 32'd100, 32'd7, 64'h0, LD);
    check("div_dbz", 64'(b32.div_by_zero), 64'h0);
    op32("div0", OP_DIV, 32'd55, 32'd0, 64'h0, 1);
    check("div0_dbz", 64'(b32.div_by_zero), 64'h0);
`endif

    // Reset pulled 10 cycles into a multiply.
    op32("pre_rst", OP_ADD, 32'd40, 32'd2, 64'd42, 1);
    wait_idle32();
    b32.start = 1'b1;
    b32.control = OP_MUL;
    b32.reg1 = 32'd3;
    b32.reg2 = 32'd5;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_z", b32.z_Output, 64'h0);
    check("midrst_busy", 64'(b32.busy), 64'h0);
    check("midrst_done", 64'(b32.done), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (b32.done) seen++;
    end
    check("midrst_nodone", 64'(seen), 64'h0);
    op32("post_rst", OP_MUL, 32'd6, 32'hFFFF_FFFC,
         64'hFFFF_FFFF_FFFF_FFE8, LM);

    // Start held high for the whole operation: exactly one done.
    wait_idle32();
    b32.start = 1'b1;
`ifdef SEQ_ALU_DIV_EN
    b32.control = OP_DIV;
`else
    b32.control = OP_MUL;
`endif
    b32.reg1 = 32'd100;
    b32.reg2 = 32'd7;
    seen = 0;
    cyc = 0;
    while (seen == 0 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (b32.done) seen++;
    end
    b32.start = 1'b0;
    check("held_lat", 64'(cyc), 64'(((b32.control == OP_MUL) ? LM : LD) + 1));
`ifdef SEQ_ALU_DIV_EN
    check("held_z", b32.z_Output, 64'h0000_0002_0000_000E);
`else
    check("held_z", b32.z_Output, 64'd700);
`endif
    repeat (40) begin
      @(posedge clk);
      #1;
      if (b32.done) seen++;
    end
    check("held_dones", 64'(seen), 64'h1);

    // Start pulsed in the done cycle is dropped.
    op32("pulse_pre", OP_OR, 32'hA000_0000, 32'h0000_000B,
         64'hA000_000B, 1);
    zprev = b32.z_Output;
    b32.start = 1'b1;
    b32.control = OP_ADD;
    b32.reg1 = 32'd1;
    b32.reg2 = 32'd1;
    @(posedge clk);
    #1;
    b32.start = 1'b0;
    check("pulse_busy", 64'(b32.busy), 64'h0);
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (b32.done) seen++;
    end
    check("pulse_nodone", 64'(seen), 64'h0);
    check("pulse_z", b32.z_Output, zprev);
    op32("pulse_post", OP_ADD, 32'd1, 32'd1, 64'd2, 1);

    // WIDTH = 8 instance.
    run8(OP_MUL, 8'hFD, 8'h07, lat);
    check("w8_mul_z", 64'(b8.z_Output), 64'hFFEB);
    check("w8_mul_lat", 64'(lat), 64'(alu_lat_mul(8)));
    run8(OP_ADD, 8'hFF, 8'h01, lat);
    check("w8_add_z", 64'(b8.z_Output), 64'h0000);
    check("w8_add_lat", 64'(lat), 64'(ALU_LAT_SINGLE));
    run8(OP_ROL, 8'h81, 8'h09, lat);
    check("w8_rol9_z", 64'(b8.z_Output), 64'h0003);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
